// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style controller: a Moore sequencer that steers the
// datapath through fetch, decode, execute, memory and writeback. The only
// inputs that reach the outputs directly are mem_ready, Op/Funct in the
// decode and execute states, and Zero (into PCEn only).
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | read instruction at PC, PC <= PC+4 when the memory is ready
// DECODE | read register file, ALUOut <= PC+4 + (SignImm<<2), pick class
// MEMADR | ALUOut <= A + SignImm (load/store effective address)
// MEMRD  | read data memory, wait on mem_ready
// MEMWB  | write loaded data into rt
// MEMWR  | write B into data memory, wait on mem_ready
// RTEXEC | ALUOut <= A op B, op taken from Funct
// RTWB   | write ALUOut into rd
// IEXEC  | ALUOut <= A op SignImm, op taken from Op
// IWB    | write ALUOut into rt
// BRANCH | compare A and B, PC <= ALUOut when the ALU reports Zero
// JUMP   | PC <= jump target

module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       PCEn,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ZERO = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXEC = 4'd6,
        RTWB   = 4'd7,
        IEXEC  = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state, state_next;

    // Raw (pre-reset-gating) control values produced by the output decoder
    logic memwrite_raw;
    logic irwrite_raw;
    logic regwrite_raw;
    logic pcwrite_raw;
    logic branch_raw;
    logic done_raw;
    logic illegal_raw;

    // Funct decode for R-type; valid flag distinguishes unsupported codes
    logic       rt_valid;
    logic [2:0] rt_alu;

    // Op decode for the immediate ALU group
    logic [2:0] imm_alu;

    // R-type funct to ALU operation
    always_comb begin
        rt_valid = 1'b1;
        rt_alu   = ALU_ADD;
        unique case (Funct)
            FN_ADD:  rt_alu = ALU_ADD;
            FN_SUB:  rt_alu = ALU_SUB;
            FN_AND:  rt_alu = ALU_AND;
            FN_OR:   rt_alu = ALU_OR;
            FN_XOR:  rt_alu = ALU_XOR;
            FN_SLT:  rt_alu = ALU_SLT;
            default: rt_valid = 1'b0;
        endcase
    end

    // Immediate-class opcode to ALU operation
    always_comb begin
        imm_alu = ALU_ADD;
        unique case (Op)
            OP_ANDI: imm_alu = ALU_AND;
            OP_ORI:  imm_alu = ALU_OR;
            OP_XORI: imm_alu = ALU_XOR;
            OP_SLTI: imm_alu = ALU_SLT;
            default: imm_alu = ALU_ADD;
        endcase
    end

    // State register; reset aborts whatever instruction is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
                if (mem_ready) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                unique case (Op)
                    OP_LW, OP_SW:           state_next = MEMADR;
                    OP_RTYPE:               state_next = RTEXEC;
                    OP_ADDI, OP_ANDI,
                    OP_ORI, OP_XORI,
                    OP_SLTI:                state_next = IEXEC;
                    OP_BEQ, OP_BNE:         state_next = BRANCH;
                    OP_J:                   state_next = JUMP;
                    default:                state_next = FETCH;
                endcase
            end
            MEMADR: begin
                // DECODE only routes loads and stores here; anything else
                // would be an IR corruption, so fall back to a fresh fetch.
                if (Op == OP_LW) begin
                    state_next = MEMRD;
                end else if (Op == OP_SW) begin
                    state_next = MEMWR;
                end else begin
                    state_next = FETCH;
                end
            end
            MEMRD: begin
                if (mem_ready) begin
                    state_next = MEMWB;
                end
            end
            MEMWB:  state_next = FETCH;
            MEMWR: begin
                if (mem_ready) begin
                    state_next = FETCH;
                end
            end
            RTEXEC: state_next = rt_valid ? RTWB : FETCH;
            RTWB:   state_next = FETCH;
            IEXEC:  state_next = IWB;
            IWB:    state_next = FETCH;
            BRANCH: state_next = FETCH;
            JUMP:   state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Datapath control decode from the current state
    always_comb begin
        IorD         = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        PCSrc        = PC_ALURES;
        ALUControl   = ALU_ADD;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        pcwrite_raw  = 1'b0;
        branch_raw   = 1'b0;
        done_raw     = 1'b0;
        illegal_raw  = 1'b0;
        unique case (state)
            FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                irwrite_raw = mem_ready;
                pcwrite_raw = mem_ready;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMMSH2;
                unique case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI, OP_BEQ, OP_BNE, OP_J: illegal_raw = 1'b0;
                    default:                                illegal_raw = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                IorD = 1'b1;
            end
            MEMWB: begin
                MemtoReg     = 1'b1;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            MEMWR: begin
                IorD         = 1'b1;
                memwrite_raw = 1'b1;
                done_raw     = mem_ready;
            end
            RTEXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUControl  = rt_alu;
                illegal_raw = ~rt_valid;
            end
            RTWB: begin
                RegDst       = 1'b1;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = imm_alu;
            end
            IWB: begin
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            BRANCH: begin
                // bne is handled by the ALU flipping Zero, so one path here
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_REG;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                branch_raw = 1'b1;
                done_raw   = 1'b1;
            end
            JUMP: begin
                ALUControl  = ALU_ZERO;
                PCSrc       = PC_JUMP;
                pcwrite_raw = 1'b1;
                done_raw    = 1'b1;
            end
            default: begin
                ALUControl = ALU_ADD;
            end
        endcase
    end

    // Architectural side effects are suppressed combinationally during
    // reset so a store or writeback in progress is cut off in that cycle.
    assign MemWrite   = memwrite_raw & ~reset;
    assign IRWrite    = irwrite_raw  & ~reset;
    assign RegWrite   = regwrite_raw & ~reset;
    assign PCEn       = (pcwrite_raw | (branch_raw & Zero)) & ~reset;
    assign instr_done = done_raw     & ~reset;
    assign illegal    = illegal_raw  & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle compares the full control
// vector against a hand-written constant for the expected state.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic       PCEn, instr_done, illegal;

    int ncmp;
    int nerr;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .PCEn       (PCEn),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
    //               ALUSrcB[1:0] PCSrc[1:0] ALUControl[2:0] PCEn done illegal
    function automatic logic [17:0] sig(
        input logic iord, input logic mw, input logic irw, input logic rd,
        input logic m2r, input logic rw, input logic sa, input logic [1:0] sb,
        input logic [1:0] pcs, input logic [2:0] alu, input logic pcen,
        input logic done, input logic ill);
        return {iord, mw, irw, rd, m2r, rw, sa, sb, pcs, alu, pcen, done, ill};
    endfunction

    logic [17:0] obs_vec;
    assign obs_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                      ALUSrcB, PCSrc, ALUControl, PCEn, instr_done, illegal};

    // Expected vectors per state
    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_OR = 6'b001101;
    localparam logic [5:0] OP_SL = 6'b001010;
    localparam logic [5:0] OP_BQ = 6'b000100;
    localparam logic [5:0] OP_BN = 6'b000101;
    localparam logic [5:0] OP_J  = 6'b000010;
    localparam logic [5:0] OP_XX = 6'b111111;

    logic [17:0] E_FETCH, E_FETCH_W, E_DEC, E_DEC_ILL, E_RT_ADD, E_RT_SUB, E_RT_ILL,
                 E_RTWB, E_MADR, E_MRD, E_MWB, E_MWR_W, E_MWR, E_MWR_RST, E_IEX_OR,
                 E_IEX_SLT, E_IWB, E_BR_T, E_BR_N, E_JUMP;

    initial begin
        E_FETCH   = sig(0,0,1,0,0,0,0,2'b01,2'b00,3'b010,1,0,0);
        E_FETCH_W = sig(0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0,0);
        E_DEC     = sig(0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0,0);
        E_DEC_ILL = sig(0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0,1);
        E_RT_ADD  = sig(0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0,0,0);
        E_RT_SUB  = sig(0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0,0,0);
        E_RT_ILL  = sig(0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0,0,1);
        E_RTWB    = sig(0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0,1,0);
        E_MADR    = sig(0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0,0);
        E_MRD     = sig(1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0,0);
        E_MWB     = sig(0,0,0,0,1,1,0,2'b00,2'b00,3'b010,0,1,0);
        E_MWR_W   = sig(1,1,0,0,0,0,0,2'b00,2'b00,3'b010,0,0,0);
        E_MWR     = sig(1,1,0,0,0,0,0,2'b00,2'b00,3'b010,0,1,0);
        E_MWR_RST = sig(1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0,0);
        E_IEX_OR  = sig(0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0,0,0);
        E_IEX_SLT = sig(0,0,0,0,0,0,1,2'b10,2'b00,3'b111,0,0,0);
        E_IWB     = sig(0,0,0,0,0,1,0,2'b00,2'b00,3'b010,0,1,0);
        E_BR_T    = sig(0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,1,0);
        E_BR_N    = sig(0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,1,0);
        E_JUMP    = sig(0,0,0,0,0,0,0,2'b00,2'b10,3'b011,1,1,0);
    end

    // One clock cycle: inputs applied shortly after the rising edge, outputs
    // compared mid-cycle, well clear of either clock edge.
    task automatic cyc(input string tag, input logic rst, input logic mr, input logic z,
                       input logic [5:0] op, input logic [5:0] fn, input logic [17:0] exp);
        @(posedge clk);
        #2;
        reset     = rst;
        mem_ready = mr;
        Zero      = z;
        Op        = op;
        Funct     = fn;
        #1;
        ncmp++;
        assert (obs_vec === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_vec, exp);
        end
    endtask

    initial begin
        ncmp      = 0;
        nerr      = 0;
        reset     = 1'b1;
        mem_ready = 1'b1;
        Zero      = 1'b0;
        Op        = 6'd0;
        Funct     = 6'd0;

        // Reset: FETCH, with write enables and PCEn forced low despite mem_ready
        cyc("reset0", 1, 1, 0, OP_R, 6'b100000, E_FETCH_W);
        cyc("reset1", 1, 1, 0, OP_R, 6'b100000, E_FETCH_W);

        // add: 4 cycles, done on cycle 4
        cyc("add_f",  0, 1, 0, OP_R, 6'b100000, E_FETCH);
        cyc("add_d",  0, 1, 0, OP_R, 6'b100000, E_DEC);
        cyc("add_ex", 0, 1, 0, OP_R, 6'b100000, E_RT_ADD);
        cyc("add_wb", 0, 1, 0, OP_J, 6'b100000, E_RTWB);

        // sub
        cyc("sub_f",  0, 1, 0, OP_R, 6'b100010, E_FETCH);
        cyc("sub_d",  0, 1, 0, OP_R, 6'b100010, E_DEC);
        cyc("sub_ex", 0, 1, 0, OP_R, 6'b100010, E_RT_SUB);
        cyc("sub_wb", 0, 1, 0, OP_R, 6'b100010, E_RTWB);

        // lw with two wait cycles in MEMRD: 7 cycles; Op wiggles while waiting
        cyc("lw_f",   0, 1, 0, OP_LW, 6'd0, E_FETCH);
        cyc("lw_d",   0, 1, 0, OP_LW, 6'd0, E_DEC);
        cyc("lw_adr", 0, 1, 0, OP_LW, 6'd0, E_MADR);
        cyc("lw_rd0", 0, 0, 0, OP_SW, 6'd0, E_MRD);
        cyc("lw_rd1", 0, 0, 0, OP_J,  6'd0, E_MRD);
        cyc("lw_rd2", 0, 1, 0, OP_LW, 6'd0, E_MRD);
        cyc("lw_wb",  0, 1, 0, OP_LW, 6'd0, E_MWB);

        // sw, no waits: 4 cycles
        cyc("sw_f",   0, 1, 0, OP_SW, 6'd0, E_FETCH);
        cyc("sw_d",   0, 1, 0, OP_SW, 6'd0, E_DEC);
        cyc("sw_adr", 0, 1, 0, OP_SW, 6'd0, E_MADR);
        cyc("sw_wr",  0, 1, 0, OP_SW, 6'd0, E_MWR);

        // ori and slti
        cyc("ori_f",  0, 1, 0, OP_OR, 6'd0, E_FETCH);
        cyc("ori_d",  0, 1, 0, OP_OR, 6'd0, E_DEC);
        cyc("ori_ex", 0, 1, 0, OP_OR, 6'd0, E_IEX_OR);
        cyc("ori_wb", 0, 1, 0, OP_OR, 6'd0, E_IWB);
        cyc("slt_f",  0, 1, 0, OP_SL, 6'd0, E_FETCH);
        cyc("slt_d",  0, 1, 0, OP_SL, 6'd0, E_DEC);
        cyc("slt_ex", 0, 1, 0, OP_SL, 6'd0, E_IEX_SLT);
        cyc("slt_wb", 0, 1, 0, OP_SL, 6'd0, E_IWB);

        // beq taken / not taken, bne with ALU reporting Zero=1
        cyc("beqt_f", 0, 1, 0, OP_BQ, 6'd0, E_FETCH);
        cyc("beqt_d", 0, 1, 0, OP_BQ, 6'd0, E_DEC);
        cyc("beqt_b", 0, 1, 1, OP_BQ, 6'd0, E_BR_T);
        cyc("beqn_f", 0, 1, 0, OP_BQ, 6'd0, E_FETCH);
        cyc("beqn_d", 0, 1, 0, OP_BQ, 6'd0, E_DEC);
        cyc("beqn_b", 0, 1, 0, OP_BQ, 6'd0, E_BR_N);
        cyc("bne_f",  0, 1, 0, OP_BN, 6'd0, E_FETCH);
        cyc("bne_d",  0, 1, 0, OP_BN, 6'd0, E_DEC);
        cyc("bne_b",  0, 1, 1, OP_BN, 6'd0, E_BR_T);

        // jump preceded by two fetch wait cycles
        cyc("j_fw0",  0, 0, 0, OP_J, 6'd0, E_FETCH_W);
        cyc("j_fw1",  0, 0, 0, OP_J, 6'd0, E_FETCH_W);
        cyc("j_f",    0, 1, 0, OP_J, 6'd0, E_FETCH);
        cyc("j_d",    0, 1, 0, OP_J, 6'd0, E_DEC);
        cyc("j_j",    0, 1, 0, OP_J, 6'd0, E_JUMP);

        // illegal opcode: flagged in DECODE, straight back to FETCH
        cyc("ilo_f",  0, 1, 0, OP_XX, 6'd0, E_FETCH);
        cyc("ilo_d",  0, 1, 0, OP_XX, 6'd0, E_DEC_ILL);

        // illegal funct: flagged in RTEXEC, no writeback
        cyc("ilf_f",  0, 1, 0, OP_R, 6'b000001, E_FETCH);
        cyc("ilf_d",  0, 1, 0, OP_R, 6'b000001, E_DEC);
        cyc("ilf_ex", 0, 1, 0, OP_R, 6'b000001, E_RT_ILL);

        // reset during a stalled store
        cyc("rst_f",  0, 1, 0, OP_SW, 6'd0, E_FETCH);
        cyc("rst_d",  0, 1, 0, OP_SW, 6'd0, E_DEC);
        cyc("rst_ad", 0, 1, 0, OP_SW, 6'd0, E_MADR);
        cyc("rst_w0", 0, 0, 0, OP_SW, 6'd0, E_MWR_W);
        cyc("rst_w1", 1, 0, 0, OP_SW, 6'd0, E_MWR_RST);
        cyc("rst_ff", 0, 1, 0, OP_R, 6'b100000, E_FETCH);
        cyc("rst_dd", 0, 1, 0, OP_R, 6'b100000, E_DEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
